comparator_3b: RTL and testbench
================================

Name: comparator_3b

Overview:
- Registered magnitude comparator for two WIDTH-bit operands; default WIDTH=3.
- Produces three mutually exclusive flags: equal, A_greater, B_greater.
- Flags are qualified by out_valid with 1-cycle latency.
- Used as a small status/decision block in datapath control logic. Supports unsigned or two's-complement comparison, selected per transaction.

Parameters:
- WIDTH, 3: operand width in bits; legal range 1..32.
- CNT_W, 8: width of statistics counters; used only when the optional feature is compiled in.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- signed_mode  input  1  0 = unsigned compare; 1 = two's-complement compare; sampled with in_valid.
- out_valid  output  1  result flags updated this cycle.
- equal  output  1  A == B.
- A_greater  output  1  A > B.
- B_greater  output  1  B > A.
- eq_count  output  CNT_W  optional-feature port only: number of equal results.
- agt_count  output  CNT_W  optional-feature port only: number of A_greater results.
- bgt_count  output  CNT_W  optional-feature port only: number of B_greater results.
- clr_stats  input  1  optional-feature port only: synchronous clear of counters.

Behaviour:
- Reset: on any rising clk edge with rst=1, all outputs go to 0 (out_valid, equal, A_greater, B_greater, and counters if present). Reset has priority over in_valid.
- Reset mid-operation: a transaction presented in the same cycle as rst is discarded; no result is produced.
- Latency: operands presented with in_valid=1 at edge N produce flags and out_valid=1 after edge N, i.e. visible during cycle N+1.
- No backpressure: every in_valid cycle yields exactly one out_valid pulse one cycle later. Back-to-back in_valid gives continuous out_valid.
- When in_valid=0: out_valid goes 0 at the next edge; equal/A_greater/B_greater hold their last values.
- Flags after reset and before the first transaction are all 0. Once any result has been produced, exactly one flag is 1 (one-hot).
- Unsigned mode: ordinary magnitude compare of A and B as 0..2^WIDTH-1.
- Signed mode: MSB is the sign bit. Range is -2^(WIDTH-1)..2^(WIDTH-1)-1. Example at WIDTH=3: 3'b101 = -3 < 3'b110 = -2; 3'b011 = 3 > 3'b100 = -4.
- Equality is mode-independent (bitwise).
- Compare logic is purely combinational from A, B, signed_mode into the output registers. There is no internal state other than the output registers and the optional counters.

Optional Feature:
- Macro: COMPARATOR_3B_STATS_EN.
- Defined:
  - Adds clr_stats, eq_count, agt_count, bgt_count.
  - On each accepted transaction (in_valid=1, rst=0), the counter matching the computed result increments at the same edge the flags register. Counts therefore reflect results already visible on the flags.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - clr_stats=1 zeroes all counters at the edge. If clr_stats and in_valid are both 1 in the same cycle, clear wins and no increment occurs.
  - rst also clears the counters.
- Undefined: those ports and registers do not exist; core behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, A=3'b011, B=3'b001 -> out_valid=0 and all flags 0 during and after reset until the first post-reset transaction.
- Unsigned sequence at WIDTH=3, back-to-back in_valid, signed_mode=0, (A,B) = (000,000), (001,010), (011,010), (101,110), (111,111) -> one cycle later each: equal=1; B_greater=1; A_greater=1; B_greater=1; equal=1. out_valid=1 for 5 consecutive cycles; flags one-hot throughout.
- Signed mode: (011,100) -> A_greater=1 (unsigned would give B_greater); (101,110) -> B_greater=1; (111,000) -> B_greater=1; (100,100) -> equal=1.
- Hold: after (011,010), drop in_valid and change A to 000 -> out_valid=0 next cycle, A_greater stays 1.
- Reset mid-stream: assert rst in the same cycle as in_valid with (001,010) -> no out_valid pulse; flags 0 next cycle.
- Stats (macro defined, CNT_W=2): 5 equal transactions -> eq_count saturates at 3. clr_stats together with in_valid -> all counters 0, no increment.

Source files
------------

// File: rtl/comparator_3b.sv
// -----------------------------------------------------------------------------
// comparator_3b
//   Registered magnitude comparator for two WIDTH-bit operands. Each accepted
//   transaction produces three one-hot flags (equal, A_greater, B_greater).
//   The flags are qualified by out_valid one cycle after the operands.
//   Each transaction selects unsigned or two's-complement comparison.
//
//   Optional build feature, enabled by defining COMPARATOR_3B_STATS_EN:
//   saturating per-result statistics counters, with a synchronous clear.
//
// Parameters
//   WIDTH  operand width, 1..32 (default 3)
//   CNT_W  statistics counter width (default 8); used only with the feature
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; takes priority over in_valid
//   in_valid     operands valid this cycle
//   A, B         operands
//   signed_mode  0 = unsigned compare, 1 = two's-complement compare
//   out_valid    flags were updated by the last edge
//   equal        A == B
//   A_greater    A > B
//   B_greater    B > A
//   clr_stats    (feature) synchronous clear of the counters; beats in_valid
//   eq_count     (feature) number of equal results, saturating
//   agt_count    (feature) number of A_greater results, saturating
//   bgt_count    (feature) number of B_greater results, saturating
//
// Handshake: there is no ready signal. Every cycle with in_valid=1 and rst=0
// is accepted. It yields exactly one out_valid=1 cycle on the following cycle.
// When out_valid=0, the flags hold the last result.
// -----------------------------------------------------------------------------
module comparator_3b #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
`ifdef COMPARATOR_3B_STATS_EN
   input  logic             clr_stats,
   output logic [CNT_W-1:0] eq_count,
   output logic [CNT_W-1:0] agt_count,
   output logic [CNT_W-1:0] bgt_count,
`endif
   output logic             out_valid,
   output logic             equal,
   output logic             A_greater,
   output logic             B_greater
);

   // Elaboration-time guard on the legal parameter ranges.
   if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
      $error("comparator_3b: WIDTH must be 1..32 and CNT_W >= 1");
   end

   logic [WIDTH-1:0] a_key;
   logic [WIDTH-1:0] b_key;
   logic             eq_c;
   logic             agt_c;
   logic             bgt_c;

   // Inverting the sign bit maps two's-complement order onto unsigned order:
   // the most negative value becomes 0 and the most positive becomes all ones.
   // One unsigned comparator then serves both modes.
   always_comb begin
      a_key = A;
      b_key = B;
      a_key[WIDTH-1] = A[WIDTH-1] ^ signed_mode;
      b_key[WIDTH-1] = B[WIDTH-1] ^ signed_mode;
      eq_c  = (A == B);
      agt_c = (a_key > b_key);
      bgt_c = (b_key > a_key);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         equal     <= 1'b0;
         A_greater <= 1'b0;
         B_greater <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            equal     <= eq_c;
            A_greater <= agt_c;
            B_greater <= bgt_c;
         end
      end
   end

`ifdef COMPARATOR_3B_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Counters move on the same edge as the flags. The counts therefore always
   // include the result now visible on the flags.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         eq_count  <= '0;
         agt_count <= '0;
         bgt_count <= '0;
      end else if (in_valid) begin
         if (eq_c && eq_count != CNT_MAX)   eq_count  <= eq_count + CNT_ONE;
         if (agt_c && agt_count != CNT_MAX) agt_count <= agt_count + CNT_ONE;
         if (bgt_c && bgt_count != CNT_MAX) bgt_count <= bgt_count + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_comparator_3b.sv
// -----------------------------------------------------------------------------
// tb_comparator_3b
//   Self-checking bench for comparator_3b. It runs directed cases, then
//   randomized stimulus. Expected values come from an integer-arithmetic
//   reference model. The counter cases build only when
//   COMPARATOR_3B_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_comparator_3b;

   localparam int W     = 3;
   localparam int CNT_W = 2;
   localparam int FULL  = 1 << W;
   localparam int HALF  = 1 << (W - 1);
   localparam int CMAX  = (1 << CNT_W) - 1;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         signed_mode = 1'b0;
   logic         out_valid, equal, A_greater, B_greater;
`ifdef COMPARATOR_3B_STATS_EN
   logic             clr_stats = 1'b0;
   logic [CNT_W-1:0] eq_count, agt_count, bgt_count;
`endif

   always #5 clk = ~clk;

   comparator_3b #(.WIDTH(W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .A           (A),
      .B           (B),
      .signed_mode (signed_mode),
`ifdef COMPARATOR_3B_STATS_EN
      .clr_stats   (clr_stats),
      .eq_count    (eq_count),
      .agt_count   (agt_count),
      .bgt_count   (bgt_count),
`endif
      .out_valid   (out_valid),
      .equal       (equal),
      .A_greater   (A_greater),
      .B_greater   (B_greater)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_pass   = 0;
   string      phase    = "init";
   logic [3:0] exp_q[$];          // {out_valid, equal, A_greater, B_greater}

   // Reference model state.
   logic m_ov = 1'b0;
   logic m_eq = 1'b0;
   logic m_agt = 1'b0;
   logic m_bgt = 1'b0;
   int   m_eqc = 0;
   int   m_agtc = 0;
   int   m_bgtc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int to_num(input logic [W-1:0] v, input logic s);
      int n;
      n = int'(v);
      if (s && n >= HALF) n = n - FULL;
      return n;
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s, input logic c);
      int av, bv;
      @(negedge clk);
      rst = r; in_valid = v; A = a; B = b; signed_mode = s;
`ifdef COMPARATOR_3B_STATS_EN
      clr_stats = c;
`endif
      av = to_num(a, s);
      bv = to_num(b, s);
      if (r) begin
         m_ov = 0; m_eq = 0; m_agt = 0; m_bgt = 0;
         m_eqc = 0; m_agtc = 0; m_bgtc = 0;
      end else begin
         m_ov = v;
         if (v) begin
            m_eq = (a == b); m_agt = (av > bv); m_bgt = (av < bv);
         end
         if (c) begin
            m_eqc = 0; m_agtc = 0; m_bgtc = 0;
         end else if (v) begin
            if (av == bv && m_eqc < CMAX) m_eqc++;
            if (av > bv && m_agtc < CMAX) m_agtc++;
            if (av < bv && m_bgtc < CMAX) m_bgtc++;
         end
      end
      exp_q.push_back({m_ov, m_eq, m_agt, m_bgt});
      @(posedge clk);
      #1;
      check({phase, ":flags"}, 32'({out_valid, equal, A_greater, B_greater}), 32'(exp_q.pop_front()));
`ifdef COMPARATOR_3B_STATS_EN
      check({phase, ":eq_cnt"},  32'(eq_count),  32'(m_eqc));
      check({phase, ":agt_cnt"}, 32'(agt_count), 32'(m_agtc));
      check({phase, ":bgt_cnt"}, 32'(bgt_count), 32'(m_bgtc));
`endif
   endtask

   task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      drive(1'b0, 1'b1, a, b, s, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset held with a live transaction on the inputs.
      phase = "reset";
      drive(1'b1, 1'b1, 3'b011, 3'b001, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 3'b011, 3'b001, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 3'b011, 3'b001, 1'b0, 1'b0);
      check("reset:all_zero", 32'({out_valid, equal, A_greater, B_greater}), 32'd0);

      // Unsigned back-to-back sequence.
      phase = "unsigned";
      txn(3'b000, 3'b000, 1'b0);
      check("unsigned:eq_000", 32'({equal, A_greater, B_greater}), 32'b100);
      txn(3'b001, 3'b010, 1'b0);
      txn(3'b011, 3'b010, 1'b0);
      txn(3'b101, 3'b110, 1'b0);
      txn(3'b111, 3'b111, 1'b0);

      // Signed mode, including the case where the unsigned answer differs.
      phase = "signed";
      txn(3'b011, 3'b100, 1'b1);
      check("signed:3_gt_m4", 32'({equal, A_greater, B_greater}), 32'b010);
      txn(3'b101, 3'b110, 1'b1);
      txn(3'b111, 3'b000, 1'b1);
      txn(3'b100, 3'b100, 1'b1);

      // Hold: the flags keep their last result while in_valid is low.
      phase = "hold";
      txn(3'b011, 3'b010, 1'b0);
      drive(1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 1'b0);

      // Reset that coincides with a transaction.
      phase = "rst_mid";
      txn(3'b110, 3'b001, 1'b0);
      drive(1'b1, 1'b1, 3'b001, 3'b010, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0);

`ifdef COMPARATOR_3B_STATS_EN
      // Counter saturation, then a clear that coincides with a transaction.
      phase = "stats";
      for (int i = 0; i < 5; i++) txn(3'(i), 3'(i), 1'b0);
      check("stats:eq_sat", 32'(eq_count), 32'd3);
      txn(3'b111, 3'b000, 1'b0);
      drive(1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 1'b1);
      check("stats:clr", 32'({eq_count, agt_count, bgt_count}), 32'd0);
`endif

      // Randomized traffic with occasional resets and clears.
      phase = "random";
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
               W'($urandom), W'($urandom), 1'($urandom),
               ($urandom_range(0, 30) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
